// File: rtl/cam_match_reader.sv
// cam_match_reader: captures a CAM match vector and returns the indices of its
// set bits as binary addresses, lowest index first, one per valid/ready
// transfer. Also reports the popcount of the captured vector and a miss pulse
// when the vector was all-zero.
module cam_match_reader #(
  parameter int NUM_ENTRIES = 16,
  parameter int ADDR_W      = 4,
  parameter int CNT_W       = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   match_vld,
  input  logic [NUM_ENTRIES-1:0] match_vec,
  output logic                   busy,
  output logic                   addr_vld,
  output logic [ADDR_W-1:0]      addr,
  input  logic                   addr_rdy,
  output logic                   last,
  output logic                   miss,
  output logic [CNT_W-1:0]       match_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                 state;
  logic [NUM_ENTRIES-1:0] pend;

  // Index of the lowest set bit; zero when the vector is empty.
  function automatic logic [ADDR_W-1:0] lowest_idx(input logic [NUM_ENTRIES-1:0] v);
    lowest_idx = '0;
    // Scanning downward lets the lowest set bit win the last assignment.
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = ADDR_W'(i);
    end
  endfunction

  // Number of set bits in the vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_ENTRIES-1:0] v);
    popcount = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      popcount = popcount + CNT_W'(v[i]);
    end
  endfunction

  logic [ADDR_W-1:0]      vec_idx;
  logic [CNT_W-1:0]       vec_cnt;
  logic [NUM_ENTRIES-1:0] addr_onehot;
  logic [NUM_ENTRIES-1:0] pend_clr;
  logic [ADDR_W-1:0]      pend_clr_idx;
  logic [CNT_W-1:0]       pend_clr_cnt;
  logic                   xfer;

  // Decode the incoming vector and the pending set with the current bit removed.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    addr_onehot       = '0;
    addr_onehot[addr] = 1'b1;
    vec_idx           = lowest_idx(match_vec);
    vec_cnt           = popcount(match_vec);
    pend_clr          = pend & ~addr_onehot;
    pend_clr_idx      = lowest_idx(pend_clr);
    pend_clr_cnt      = popcount(pend_clr);
  end

  assign xfer = ena & addr_vld & addr_rdy;
  assign busy = (state == EMIT);

  // Capture/emit FSM with all outputs registered; reset wins over enable.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state     <= IDLE;
      pend      <= '0;
      addr      <= '0;
      addr_vld  <= 1'b0;
      last      <= 1'b0;
      miss      <= 1'b0;
      match_cnt <= '0;
    end else if (ena) begin
      miss <= 1'b0;
      case (state)
        IDLE: begin
          if (match_vld) begin
            pend      <= match_vec;
            match_cnt <= vec_cnt;
            if (match_vec == '0) begin
              miss <= 1'b1;
            end else begin
              state    <= EMIT;
              addr     <= vec_idx;
              last     <= (vec_cnt == CNT_W'(1));
              addr_vld <= 1'b1;
            end
          end
        end
        EMIT: begin
          // Strobes arriving here are ignored, including on the final transfer.
          if (xfer) begin
            pend <= pend_clr;
            if (last) begin
              addr_vld <= 1'b0;
              last     <= 1'b0;
              state    <= IDLE;
            end else begin
              addr <= pend_clr_idx;
              last <= (pend_clr_cnt == CNT_W'(1));
            end
          end
        end
      endcase
    end else begin
      // Disabled: everything holds except the miss pulse, which is dropped.
      miss <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cam_match_reader.sv
// Self-checking bench for cam_match_reader: directed scenarios followed by
// random traffic, all compared each cycle against a queue-based reference.
module tb_cam_match_reader;

  localparam int NUM_ENTRIES = 16;
  localparam int ADDR_W      = 4;
  localparam int CNT_W       = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   ena;
  logic                   match_vld;
  logic [NUM_ENTRIES-1:0] match_vec;
  logic                   busy;
  logic                   addr_vld;
  logic [ADDR_W-1:0]      addr;
  logic                   addr_rdy;
  logic                   last;
  logic                   miss;
  logic [CNT_W-1:0]       match_cnt;

  int errors = 0;
  int checks = 0;

  // Reference: the remaining matches as a list of indices, plus count and miss.
  int q[$];
  int exp_cnt  = 0;
  bit exp_miss = 1'b0;

  always #5 clk = ~clk;

  cam_match_reader #(
    .NUM_ENTRIES(NUM_ENTRIES),
    .ADDR_W     (ADDR_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .match_vld(match_vld),
    .match_vec(match_vec),
    .busy     (busy),
    .addr_vld (addr_vld),
    .addr     (addr),
    .addr_rdy (addr_rdy),
    .last     (last),
    .miss     (miss),
    .match_cnt(match_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the reference by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    bit was_busy;
    if (rst) begin
      q.delete();
      exp_cnt  = 0;
      exp_miss = 1'b0;
    end else if (ena) begin
      was_busy = (q.size() > 0);
      exp_miss = 1'b0;
      if (was_busy) begin
        if (addr_rdy) void'(q.pop_front());
      end else if (match_vld) begin
        exp_cnt = 0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (match_vec[i]) begin
            q.push_back(i);
            exp_cnt++;
          end
        end
        exp_miss = (exp_cnt == 0);
      end
    end else begin
      exp_miss = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".addr_vld"}, 32'(addr_vld), 32'(q.size() > 0));
    check({tag, ".busy"},     32'(busy),     32'(q.size() > 0));
    check({tag, ".miss"},     32'(miss),     32'(exp_miss));
    check({tag, ".cnt"},      32'(match_cnt), 32'(exp_cnt));
    if (q.size() > 0) begin
      check({tag, ".addr"}, 32'(addr), 32'(q[0]));
      check({tag, ".last"}, 32'(last), 32'(q.size() == 1));
    end else begin
      check({tag, ".last"}, 32'(last), 32'd0);
    end
  endtask

  // Drive one cycle of inputs, clock it, update the reference and compare.
  task automatic cyc(input string tag, input bit r, input bit e, input bit v,
                     input logic [NUM_ENTRIES-1:0] vec, input bit rdy);
    rst       = r;
    ena       = e;
    match_vld = v;
    match_vec = vec;
    addr_rdy  = rdy;
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [NUM_ENTRIES-1:0] rand_vec();
    logic [NUM_ENTRIES-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2: begin v = '0; v[$urandom_range(0, NUM_ENTRIES - 1)] = 1'b1; end
      3:       v = NUM_ENTRIES'($urandom) & NUM_ENTRIES'($urandom);
      default: v = NUM_ENTRIES'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    rst = 1'b1; ena = 1'b0; match_vld = 1'b0; match_vec = '0; addr_rdy = 1'b0;

    // Reset state.
    cyc("reset", 1, 0, 0, '0, 0);
    cyc("reset", 1, 1, 1, 16'hFFFF, 1);

    // 1: reset mid-scan after one transfer, then a normal strobe.
    cyc("t1", 0, 1, 1, 16'h00F0, 0);
    cyc("t1", 0, 1, 0, '0, 1);
    cyc("t1", 1, 1, 0, '0, 1);
    cyc("t1", 0, 1, 1, 16'h0003, 1);
    for (int i = 0; i < 3; i++) cyc("t1", 0, 1, 0, '0, 1);

    // 2: four spread matches drained back to back.
    cyc("t2", 0, 1, 1, 16'h8421, 1);
    for (int i = 0; i < 5; i++) cyc("t2", 0, 1, 0, '0, 1);

    // 3: empty vector gives a single miss pulse.
    cyc("t3", 0, 1, 1, 16'h0000, 1);
    for (int i = 0; i < 2; i++) cyc("t3", 0, 1, 0, '0, 1);

    // 4: downstream stalls for three cycles, then accepts.
    cyc("t4", 0, 1, 1, 16'h0006, 0);
    for (int i = 0; i < 3; i++) cyc("t4", 0, 1, 0, '0, 0);
    cyc("t4", 0, 1, 0, '0, 1);
    cyc("t4", 0, 1, 0, '0, 1);

    // 5: strobe while busy is ignored, strobe on the final transfer too,
    //    then an all-ones vector gives 16 transfers.
    cyc("t5", 0, 1, 1, 16'h0012, 0);
    cyc("t5", 0, 1, 1, 16'hFFFF, 1);
    cyc("t5", 0, 1, 1, 16'hFFFF, 1);
    cyc("t5", 0, 1, 1, 16'hFFFF, 1);
    for (int i = 0; i < 17; i++) cyc("t5", 0, 1, 0, '0, 1);

    // 6: disable during a scan with ready high, then resume.
    cyc("t6", 0, 1, 1, 16'h0C00, 0);
    for (int i = 0; i < 3; i++) cyc("t6", 0, 0, 1, 16'h0001, 1);
    for (int i = 0; i < 3; i++) cyc("t6", 0, 1, 0, '0, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc("rnd",
          ($urandom_range(0, 99) == 0),
          ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 2) == 0),
          rand_vec(),
          ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
